// File: rtl/xmpl_sram_pkg.sv
// Shared types and constants for the processor SRAM responder.
// The address/data widths match the core's SRAM port declarations.
package xmpl_sram_pkg;

    localparam int unsigned SRAM_ADDR_W = 12;
    localparam int unsigned SRAM_DATA_W = 32;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } sram_state_e;

    // Counter width needed to walk DEPTH words; never narrower than one bit.
    function automatic int unsigned sram_cnt_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/xmpl_sram_rd_pipe.sv
// Read-data delay line of RD_LAT valid/data stages. The output holds the last
// valid result so writes and idle cycles never disturb what the core sees.
module xmpl_sram_rd_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];
    logic [DATA_W-1:0] hold_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_q  <= '0;
            hold_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid_i;
            dat_q[0] <= in_data_i;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            hold_q <= rdata_o;
        end
    end

    // Last stage lands in the cycle it becomes valid; otherwise replay the held word.
    always_comb begin
        rdata_o = hold_q;
        if (vld_q[RD_LAT-1]) begin
            rdata_o = dat_q[RD_LAT-1];
        end
    end

endmodule

// File: rtl/xmpl_sram_resp.sv
// Responder end of the processor SRAM port: register-array memory cleared by
// an init sweep after reset, fixed-latency reads and a sticky protocol error.
module xmpl_sram_resp
    import xmpl_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DATA_W = SRAM_DATA_W,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              sram_en_i,
    input  logic [ADDR_W-1:0] sram_addr_i,
    input  logic              sram_rw_i,
    input  logic [DATA_W-1:0] sram_wdata_i,
    output logic [DATA_W-1:0] sram_rdata_o,
    output logic              sram_busy_o,
    output logic              sram_err_o,
    input  logic              sram_err_clr_i
);

    localparam int unsigned       CNT_W     = sram_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
        $error("xmpl_sram_resp: RD_LAT must be 1..3");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("xmpl_sram_resp: DEPTH must be 1..2**ADDR_W");
    end

    sram_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              in_range;
    logic [CNT_W-1:0]  addr_idx;
    logic              req_wr;
    logic              req_rd;
    logic              err_set;
    logic [DATA_W-1:0] rd_data;

    assign ready    = (state_q == READY);
    assign in_range = ({1'b0, sram_addr_i} < DEPTH_EXT);
    assign addr_idx = sram_addr_i[CNT_W-1:0];
    assign req_wr   = ready & sram_en_i & sram_rw_i & in_range;
    // Out-of-range reads still occupy a pipeline slot and return zero.
    assign req_rd   = ready & sram_en_i & ~sram_rw_i;
    assign err_set  = sram_en_i & (~ready | ~in_range);

    // Init FSM: one word cleared per cycle, busy drops with the final word.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                INIT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                READY: begin
                    state_q <= READY;
                end
                default: begin
                    state_q <= INIT;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Array has no reset; the init sweep is what clears it.
    always_ff @(posedge clk_i) begin
        if (state_q == INIT) begin
            mem[cnt_q] <= '0;
        end else if (req_wr) begin
            mem[addr_idx] <= sram_wdata_i;
        end
    end

    always_comb begin
        rd_data = '0;
        if (in_range) begin
            rd_data = mem[addr_idx];
        end
    end

    // A new error on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (sram_err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    xmpl_sram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .in_valid_i (req_rd),
        .in_data_i  (rd_data),
        .rdata_o    (sram_rdata_o)
    );

    assign sram_busy_o = busy_q;
    assign sram_err_o  = err_q;

endmodule

// File: tb/tb_xmpl_sram_resp.sv
// Directed bench: two responders (read latency 1 and 3, 16 words) share one
// stimulus stream; a vector table plus init/reset sequences check both.
module tb_xmpl_sram_resp;

    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] V5 = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        rw = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        clr = 1'b0;

    logic [31:0] rdata1, rdata3;
    logic        busy1, busy3, err1, err3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    xmpl_sram_resp #(
        .ADDR_W (12),
        .DATA_W (32),
        .DEPTH  (16),
        .RD_LAT (1)
    ) u_dut1 (
        .clk_i          (clk),
        .reset_i        (reset),
        .sram_en_i      (en),
        .sram_addr_i    (addr),
        .sram_rw_i      (rw),
        .sram_wdata_i   (wdata),
        .sram_rdata_o   (rdata1),
        .sram_busy_o    (busy1),
        .sram_err_o     (err1),
        .sram_err_clr_i (clr)
    );

    xmpl_sram_resp #(
        .ADDR_W (12),
        .DATA_W (32),
        .DEPTH  (16),
        .RD_LAT (3)
    ) u_dut3 (
        .clk_i          (clk),
        .reset_i        (reset),
        .sram_en_i      (en),
        .sram_addr_i    (addr),
        .sram_rw_i      (rw),
        .sram_wdata_i   (wdata),
        .sram_rdata_o   (rdata3),
        .sram_busy_o    (busy3),
        .sram_err_o     (err3),
        .sram_err_clr_i (clr)
    );

    typedef struct {
        logic        en;
        logic        rw;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        clr;
        logic [31:0] exp1;
        logic [31:0] exp3;
        logic        exp_err;
    } vec_t;

    vec_t vecs [30];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic w, input logic [11:0] a,
                         input logic [31:0] d, input logic c);
        en    = e;
        rw    = w;
        addr  = a;
        wdata = d;
        clr   = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fall;
        logic stale;

        //          en    rw    addr     wdata         clr   exp1         exp3         err
        vecs[0]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0,       32'h0,       1'b0};
        vecs[1]  = '{1'b1, 1'b1, 12'h005, DB,           1'b0, 32'h0,       32'h0,       1'b0};
        vecs[2]  = '{1'b1, 1'b0, 12'h005, 32'h0,        1'b0, DB,          32'h0,       1'b0};
        vecs[3]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, DB,          32'h0,       1'b0};
        vecs[4]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, DB,          DB,          1'b0};
        vecs[5]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, DB,          DB,          1'b0};
        vecs[6]  = '{1'b1, 1'b0, 12'h003, 32'h0,        1'b0, 32'h0,       DB,          1'b0};
        vecs[7]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 32'h0,       DB,          1'b0};
        vecs[8]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 32'h0,       32'h0,       1'b0};
        vecs[9]  = '{1'b1, 1'b1, 12'h001, 32'h11,       1'b0, 32'h0,       32'h0,       1'b0};
        vecs[10] = '{1'b1, 1'b1, 12'h002, 32'h22,       1'b0, 32'h0,       32'h0,       1'b0};
        vecs[11] = '{1'b1, 1'b1, 12'h003, 32'h33,       1'b0, 32'h0,       32'h0,       1'b0};
        vecs[12] = '{1'b1, 1'b0, 12'h001, 32'h0,        1'b0, 32'h11,      32'h0,       1'b0};
        vecs[13] = '{1'b1, 1'b0, 12'h002, 32'h0,        1'b0, 32'h22,      32'h0,       1'b0};
        vecs[14] = '{1'b1, 1'b0, 12'h003, 32'h0,        1'b0, 32'h33,      32'h11,      1'b0};
        vecs[15] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 32'h33,      32'h22,      1'b0};
        vecs[16] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 32'h33,      32'h33,      1'b0};
        vecs[17] = '{1'b1, 1'b0, 12'h00F, 32'h0,        1'b0, 32'h0,       32'h33,      1'b0};
        vecs[18] = '{1'b1, 1'b1, 12'h00F, V5,           1'b0, 32'h0,       32'h33,      1'b0};
        vecs[19] = '{1'b1, 1'b0, 12'h00F, 32'h0,        1'b0, V5,          32'h0,       1'b0};
        vecs[20] = '{1'b1, 1'b1, 12'h010, 32'hFFFFFFFF, 1'b0, V5,          32'h0,       1'b1};
        vecs[21] = '{1'b1, 1'b0, 12'h000, 32'h0,        1'b0, 32'h0,       V5,          1'b1};
        vecs[22] = '{1'b1, 1'b0, 12'h001, 32'h0,        1'b1, 32'h11,      V5,          1'b0};
        vecs[23] = '{1'b1, 1'b0, 12'h020, 32'h0,        1'b0, 32'h0,       32'h0,       1'b1};
        vecs[24] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 32'h0,       32'h11,      1'b1};
        vecs[25] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0,       32'h0,       1'b0};
        vecs[26] = '{1'b1, 1'b1, 12'h020, 32'hFFFFFFFF, 1'b1, 32'h0,       32'h0,       1'b1};
        vecs[27] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 32'h0,       32'h0,       1'b1};
        vecs[28] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0,       32'h0,       1'b0};
        vecs[29] = '{1'b1, 1'b0, 12'h005, 32'h0,        1'b0, DB,          32'h0,       1'b0};

        // Reset state
        repeat (3) tick();
        check("reset rdata1", rdata1, 32'h0);
        check("reset rdata3", rdata3, 32'h0);
        check("reset busy1", {31'b0, busy1}, 32'h1);
        check("reset err1", {31'b0, err1}, 32'h0);

        // Init sweep with a write attempt to addr 3 on the 10th edge
        reset = 1'b0;
        fall = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) drive(1'b1, 1'b1, 12'h003, 32'h0000AAAA, 1'b0);
            else         drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0);
            tick();
            if (!busy1) begin
                fall = k;
                break;
            end
        end
        drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0);
        check("init busy fall edge", fall, 16);
        check("init busy3", {31'b0, busy3}, 32'h0);
        check("init req err1", {31'b0, err1}, 32'h1);
        check("init req err3", {31'b0, err3}, 32'h1);
        check("init rdata1", rdata1, 32'h0);

        // Table-driven traffic
        for (int i = 0; i < 30; i++) begin
            drive(vecs[i].en, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].clr);
            tick();
            check($sformatf("row%0d rdata1", i), rdata1, vecs[i].exp1);
            check($sformatf("row%0d rdata3", i), rdata3, vecs[i].exp3);
            check($sformatf("row%0d err1", i), {31'b0, err1}, {31'b0, vecs[i].exp_err});
            check($sformatf("row%0d err3", i), {31'b0, err3}, {31'b0, vecs[i].exp_err});
            check($sformatf("row%0d busy1", i), {31'b0, busy1}, 32'h0);
        end

        // Reset with a read in flight in the latency-3 pipe
        drive(1'b1, 1'b0, 12'h005, 32'h0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        check("midreset rdata1", rdata1, 32'h0);
        check("midreset rdata3", rdata3, 32'h0);
        check("midreset busy1", {31'b0, busy1}, 32'h1);
        check("midreset busy3", {31'b0, busy3}, 32'h1);
        repeat (2) tick();
        reset = 1'b0;
        fall = 0;
        stale = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (rdata1 !== 32'h0 || rdata3 !== 32'h0) stale = 1'b1;
            if (!busy3) begin
                fall = k;
                break;
            end
        end
        check("reinit busy fall edge", fall, 16);
        check("reinit stale data", {31'b0, stale}, 32'h0);
        repeat (4) tick();
        check("post reinit rdata3", rdata3, 32'h0);
        check("post reinit rdata1", rdata1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
